// File: rtl/double_ceil_arbiter.sv
// Shares one fixed-latency double_ceil pipe between NUM_REQ requesters with credit-protected
// per-port result FIFOs. Define DOUBLE_CEIL_ARB_PRIORITY_EN for fixed priority instead of round-robin.
module double_ceil_arbiter #(
   parameter int unsigned NUM_REQ    = 2,
   parameter int unsigned LATENCY    = 4,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ*64-1:0] in_a,
   input  logic [NUM_REQ-1:0]    in_valid,
   output logic [NUM_REQ-1:0]    in_ready,
   output logic [NUM_REQ*64-1:0] out_z,
   output logic [NUM_REQ-1:0]    out_valid,
   input  logic [NUM_REQ-1:0]    out_ready,
   output logic [63:0]           ceil_a,
   input  logic [63:0]           ceil_z
);
   localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW-1:0] FULL_CREDIT = CW'(FIFO_DEPTH);

   logic [NUM_REQ-1:0] eligible;
   logic [NUM_REQ-1:0] push;
   logic [NUM_REQ-1:0] pop;
   logic               arb_hit;
   logic [IDW-1:0]     arb_id;
   logic               grant_any;
   logic [IDW-1:0]     grant_id;
   logic [63:0]        sel_a;
   logic [63:0]        ceil_a_q;
   logic [LATENCY-1:0] tag_v_q;
   logic [IDW-1:0]     tag_id_q [LATENCY];
   logic [CW-1:0]      credit_q [NUM_REQ];
   logic [CW-1:0]      credit_d [NUM_REQ];
   logic [CW-1:0]      cnt_q    [NUM_REQ];
   logic [CW-1:0]      cnt_d    [NUM_REQ];
   logic [PW-1:0]      wr_q     [NUM_REQ];
   logic [PW-1:0]      rd_q     [NUM_REQ];
   logic [63:0]        mem_q    [NUM_REQ][FIFO_DEPTH];

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (FIFO_DEPTH == 1) return '0;
      return p + 1'b1;
   endfunction

   always_comb begin
      eligible = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++)
         eligible[i] = in_valid[i] && (credit_q[i] != '0);
   end

`ifdef DOUBLE_CEIL_ARB_PRIORITY_EN
   always_comb begin
      arb_hit = 1'b0;
      arb_id  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!arb_hit && eligible[i]) begin
            arb_hit = 1'b1;
            arb_id  = IDW'(i);
         end
      end
   end
`else
   logic [IDW-1:0] rr_q;
   logic [IDW-1:0] cand;

   // Search starts one past the last winner so the previous grantee goes last.
   always_comb begin
      arb_hit = 1'b0;
      arb_id  = '0;
      cand    = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         cand = IDW'((32'(rr_q) + k) % NUM_REQ);
         if (!arb_hit && eligible[cand]) begin
            arb_hit = 1'b1;
            arb_id  = cand;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)            rr_q <= '0;
      else if (grant_any) rr_q <= grant_id;
   end
`endif

   assign grant_any = arb_hit && !rst;
   assign grant_id  = arb_id;
   assign ceil_a    = ceil_a_q;

   always_comb begin
      in_ready = '0;
      if (grant_any) in_ready[grant_id] = 1'b1;
   end

   always_comb begin
      sel_a = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++)
         if (arb_id == IDW'(i)) sel_a = in_a[64*i +: 64];
   end

   // The last tag stage lines up with ceil_z; its id steers the result into that port's FIFO.
   always_comb begin
      out_valid = '0;
      out_z     = '0;
      push      = '0;
      pop       = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         out_valid[i]      = (cnt_q[i] != '0);
         out_z[64*i +: 64] = mem_q[i][rd_q[i]];
         pop[i]            = out_valid[i] && out_ready[i];
         push[i]           = tag_v_q[LATENCY-1] && (tag_id_q[LATENCY-1] == IDW'(i));
         cnt_d[i]          = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
         credit_d[i]       = credit_q[i] - CW'(in_ready[i]) + CW'(pop[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ceil_a_q <= '0;
         tag_v_q  <= '0;
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            credit_q[i] <= FULL_CREDIT;
            cnt_q[i]    <= '0;
            wr_q[i]     <= '0;
            rd_q[i]     <= '0;
         end
      end else begin
         if (grant_any) ceil_a_q <= sel_a;
         tag_v_q[0] <= grant_any;
         for (int unsigned s = 1; s < LATENCY; s++)
            tag_v_q[s] <= tag_v_q[s-1];
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            credit_q[i] <= credit_d[i];
            cnt_q[i]    <= cnt_d[i];
            if (push[i]) wr_q[i] <= ptr_inc(wr_q[i]);
            if (pop[i])  rd_q[i] <= ptr_inc(rd_q[i]);
         end
      end
   end

   always_ff @(posedge clk) begin
      tag_id_q[0] <= grant_id;
      for (int unsigned s = 1; s < LATENCY; s++)
         tag_id_q[s] <= tag_id_q[s-1];
      for (int unsigned i = 0; i < NUM_REQ; i++)
         if (push[i]) mem_q[i][wr_q[i]] <= ceil_z;
   end

endmodule

// File: tb/tb_double_ceil_arbiter.sv
// Bench for double_ceil_arbiter: behavioural fixed-latency ceil unit, directed scenarios,
// and random traffic checked against a queue-per-port occupancy model.
module tb_double_ceil_arbiter;
   localparam int N = 2;
   localparam int L = 4;
   localparam int D = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [N*64-1:0] in_a;
   logic [N-1:0]    in_valid;
   logic [N-1:0]    in_ready;
   logic [N*64-1:0] out_z;
   logic [N-1:0]    out_valid;
   logic [N-1:0]    out_ready;
   logic [63:0]     ceil_a;
   logic [63:0]     ceil_z;
   logic [63:0]     upipe [L-1];

   typedef struct { logic [63:0] v; int t; } ent_t;
   ent_t         mq [N][$];
   int           cyc, g_id, n_cmp, n_bad;
`ifndef DOUBLE_CEIL_ARB_PRIORITY_EN
   int           m_rr;
`endif
   logic [63:0]  m_ceil_a;
   logic [N-1:0] e_ready, e_valid;
   logic [63:0]  e_z [N];

   always #5 clk = ~clk;

   double_ceil_arbiter #(.NUM_REQ(N), .LATENCY(L), .FIFO_DEPTH(D)) dut (
      .clk(clk), .rst(rst), .in_a(in_a), .in_valid(in_valid), .in_ready(in_ready),
      .out_z(out_z), .out_valid(out_valid), .out_ready(out_ready),
      .ceil_a(ceil_a), .ceil_z(ceil_z)
   );

   function automatic logic [63:0] dceil(input logic [63:0] a);
      return $realtobits($ceil($bitstoreal(a)));
   endfunction

   function automatic logic [63:0] rand_op();
      real r;
      r = (real'($urandom_range(0, 4000)) - 2000.0) / 16.0;
      return $realtobits(r);
   endfunction

   // External unit: ceil_a is its first stage, L-1 further stages to ceil_z.
   always @(posedge clk) begin
      upipe[0] <= ceil_a;
      for (int k = 1; k < L-1; k++) upipe[k] <= upipe[k-1];
   end
   assign ceil_z = dceil(upipe[L-2]);

   // Model: a port's queue holds everything granted and not yet popped, so credit = D - size.
   task automatic model_eval();
      e_ready = '0;
      g_id    = -1;
      for (int i = 0; i < N; i++) begin
         e_valid[i] = (mq[i].size() > 0) && (mq[i][0].t <= cyc);
         e_z[i]     = e_valid[i] ? mq[i][0].v : 64'h0;
      end
`ifdef DOUBLE_CEIL_ARB_PRIORITY_EN
      for (int i = 0; i < N; i++)
         if (g_id < 0 && in_valid[i] && mq[i].size() < D) g_id = i;
`else
      for (int k = 1; k <= N; k++) begin
         int j;
         j = (m_rr + k) % N;
         if (g_id < 0 && in_valid[j] && mq[j].size() < D) g_id = j;
      end
`endif
      if (rst) g_id = -1;
      if (g_id >= 0) e_ready[g_id] = 1'b1;
   endtask

   task automatic model_commit();
      if (rst) begin
         for (int i = 0; i < N; i++) mq[i].delete();
`ifndef DOUBLE_CEIL_ARB_PRIORITY_EN
         m_rr = 0;
`endif
         m_ceil_a = '0;
      end else begin
         for (int i = 0; i < N; i++)
            if (e_valid[i] && out_ready[i]) void'(mq[i].pop_front());
         if (g_id >= 0) begin
            ent_t e;
            e.v = dceil(in_a[64*g_id +: 64]);
            e.t = cyc + L + 1;
            mq[g_id].push_back(e);
            m_ceil_a = in_a[64*g_id +: 64];
`ifndef DOUBLE_CEIL_ARB_PRIORITY_EN
            m_rr = g_id;
`endif
         end
      end
      cyc++;
   endtask

   task automatic tick();
      model_eval();
      model_commit();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = '0; out_ready = '0; in_a = '0;
      tick();
      in_valid = '1;
      #1;
      n_cmp++; if (in_ready !== 2'b00) begin n_bad++; $display("FAIL reset_ready_in_rst got=%b exp=00", in_ready); end
      tick();
      rst = 1'b0; in_valid = '0;
      #1;
      n_cmp++; if (in_ready !== 2'b00) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=00", in_ready); end
      n_cmp++; if (out_valid !== 2'b00) begin n_bad++; $display("FAIL reset_out_valid got=%b exp=00", out_valid); end
      n_cmp++; if (ceil_a !== 64'h0) begin n_bad++; $display("FAIL reset_ceil_a got=%h exp=0", ceil_a); end
   endtask

   task automatic test_single();
      out_ready = '1;
      in_a[63:0] = 64'h3FF8000000000000;
      in_valid = 2'b01;
      #1;
      n_cmp++; if (in_ready !== 2'b01) begin n_bad++; $display("FAIL single_grant got=%b exp=01", in_ready); end
      tick();
      in_valid = '0;
      for (int k = 1; k <= L + 2; k++) begin
         #1;
         n_cmp++; if (ceil_a !== 64'h3FF8000000000000) begin n_bad++; $display("FAIL single_ceil_a_hold k=%0d got=%h exp=3ff8000000000000", k, ceil_a); end
         if (k == L + 1) begin
            n_cmp++; if (out_valid !== 2'b01) begin n_bad++; $display("FAIL single_out_valid k=%0d got=%b exp=01", k, out_valid); end
            n_cmp++; if (out_z[63:0] !== 64'h4000000000000000) begin n_bad++; $display("FAIL single_out_z got=%h exp=4000000000000000", out_z[63:0]); end
         end else begin
            n_cmp++; if (out_valid !== 2'b00) begin n_bad++; $display("FAIL single_no_push k=%0d got=%b exp=00", k, out_valid); end
         end
         tick();
      end
   endtask

`ifndef DOUBLE_CEIL_ARB_PRIORITY_EN
   task automatic test_round_robin();
      int last, g;
      last = -1;
      in_valid = '1; out_ready = '1;
      for (int c = 0; c < 16; c++) begin
         in_a[63:0]   = rand_op();
         in_a[127:64] = 64'hBFF8000000000000;
         #1;
         g = (in_ready == 2'b01) ? 0 : (in_ready == 2'b10) ? 1 : -1;
         if (c == 0) begin
            n_cmp++; if (g != 1) begin n_bad++; $display("FAIL rr_first got=%0d exp=1", g); end
         end
         n_cmp++; if (g < 0 || g == last) begin n_bad++; $display("FAIL rr_alternate c=%0d got=%0d prev=%0d", c, g, last); end
         if (out_valid[1]) begin
            n_cmp++; if (out_z[127:64] !== 64'hBFF0000000000000) begin n_bad++; $display("FAIL rr_port1_z got=%h exp=bff0000000000000", out_z[127:64]); end
         end
         last = g;
         tick();
      end
      in_valid = '0;
      for (int c = 0; c < L + 3; c++) begin
         #1;
         if (out_valid[1]) begin
            n_cmp++; if (out_z[127:64] !== 64'hBFF0000000000000) begin n_bad++; $display("FAIL rr_drain_port1_z got=%h exp=bff0000000000000", out_z[127:64]); end
         end
         tick();
      end
   endtask
`else
   task automatic test_priority();
      in_valid = '1; out_ready = '1;
      for (int c = 0; c < 30; c++) begin
         for (int i = 0; i < N; i++) in_a[64*i +: 64] = rand_op();
         #1;
         if (mq[0].size() < D) begin
            n_cmp++; if (in_ready !== 2'b01) begin n_bad++; $display("FAIL prio_port0_wins c=%0d got=%b exp=01", c, in_ready); end
         end
         tick();
      end
      in_valid = '0;
      for (int c = 0; c < L + 3; c++) tick();
   endtask
`endif

   task automatic test_backpressure();
      int g0, g1;
      logic [63:0] sent [$];
      logic [63:0] exp_v;
      g0 = 0; g1 = 0;
      out_ready = 2'b10; in_valid = 2'b11;
      for (int c = 0; c < 20; c++) begin
         for (int i = 0; i < N; i++) in_a[64*i +: 64] = rand_op();
         #1;
         if (in_ready[0]) begin g0++; sent.push_back(dceil(in_a[63:0])); end
         if (in_ready[1]) g1++;
         tick();
      end
      #1;
      n_cmp++; if (g0 != D) begin n_bad++; $display("FAIL bp_port0_grants got=%0d exp=%0d", g0, D); end
      n_cmp++; if (g1 == 0) begin n_bad++; $display("FAIL bp_port1_served got=%0d exp>0", g1); end
      n_cmp++; if (in_ready[0] !== 1'b0) begin n_bad++; $display("FAIL bp_port0_blocked got=%b exp=0", in_ready[0]); end
      in_valid = '0; out_ready = '1;
      for (int c = 0; c < L + 8; c++) begin
         #1;
         if (out_valid[0]) begin
            exp_v = (sent.size() > 0) ? sent.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
            n_cmp++; if (out_z[63:0] !== exp_v) begin n_bad++; $display("FAIL bp_drain_order got=%h exp=%h", out_z[63:0], exp_v); end
         end
         tick();
      end
      n_cmp++; if (sent.size() != 0) begin n_bad++; $display("FAIL bp_results_lost got=%0d left exp=0", sent.size()); end
   endtask

   task automatic test_reset_flight();
      int g0;
      g0 = 0;
      in_valid = 2'b11; out_ready = '0;
      for (int c = 0; c < 3; c++) begin
         for (int i = 0; i < N; i++) in_a[64*i +: 64] = rand_op();
         tick();
      end
      in_valid = '0; rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      n_cmp++; if (ceil_a !== 64'h0) begin n_bad++; $display("FAIL flush_ceil_a got=%h exp=0", ceil_a); end
      n_cmp++; if (in_ready !== 2'b00) begin n_bad++; $display("FAIL flush_in_ready got=%b exp=00", in_ready); end
      for (int c = 0; c < L + 3; c++) begin
         #1;
         n_cmp++; if (out_valid !== 2'b00) begin n_bad++; $display("FAIL flush_out_valid c=%0d got=%b exp=00", c, out_valid); end
         tick();
      end
      in_valid = 2'b01;
      for (int c = 0; c < 10; c++) begin
         in_a[63:0] = rand_op();
         #1;
         if (in_ready[0]) g0++;
         tick();
      end
      n_cmp++; if (g0 != D) begin n_bad++; $display("FAIL flush_credits got=%0d exp=%0d", g0, D); end
      in_valid = '0; out_ready = '1;
      for (int c = 0; c < L + 6; c++) tick();
   endtask

   task automatic test_random();
      for (int c = 0; c < 300; c++) begin
         for (int i = 0; i < N; i++) begin
            in_a[64*i +: 64] = rand_op();
            in_valid[i]      = ($urandom_range(0, 3) != 0);
            out_ready[i]     = ($urandom_range(0, 3) != 0);
         end
         #1;
         model_eval();
         n_cmp++; if (in_ready !== e_ready) begin n_bad++; $display("FAIL rand_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, e_ready); end
         n_cmp++; if (out_valid !== e_valid) begin n_bad++; $display("FAIL rand_out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, e_valid); end
         n_cmp++; if (ceil_a !== m_ceil_a) begin n_bad++; $display("FAIL rand_ceil_a cyc=%0d got=%h exp=%h", cyc, ceil_a, m_ceil_a); end
         for (int i = 0; i < N; i++) begin
            if (e_valid[i]) begin
               n_cmp++; if (out_z[64*i +: 64] !== e_z[i]) begin n_bad++; $display("FAIL rand_out_z port=%0d cyc=%0d got=%h exp=%h", i, cyc, out_z[64*i +: 64], e_z[i]); end
            end
         end
         tick();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp = 0; n_bad = 0; cyc = 0; g_id = -1; m_ceil_a = '0;
`ifndef DOUBLE_CEIL_ARB_PRIORITY_EN
      m_rr = 0;
`endif
      rst = 1'b1; in_valid = '0; out_ready = '0; in_a = '0;
      @(negedge clk);
      test_reset();
      test_single();
`ifndef DOUBLE_CEIL_ARB_PRIORITY_EN
      test_round_robin();
`else
      test_priority();
`endif
      test_backpressure();
      test_reset_flight();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
